// File: rtl/in_fifo_arbiter_pkg.sv
// Shared types and helpers for the IN-side byte arbiter and IN FIFO.
package in_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DATA_W             = 8;
  localparam int IN_MAX_PACKET_SIZE = 8;

  function automatic int ceil_log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Width of a counter that must hold 0..max_burst inclusive.
  function automatic int burst_cnt_w(input int max_burst);
    return ceil_log2(max_burst + 1);
  endfunction

endpackage

// File: rtl/in_fifo_arbiter_if.sv
// Requester byte streams plus the IN FIFO application port, as seen by the arbiter.
interface in_fifo_arbiter_if
  import in_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
);
  logic [DATA_W*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_last_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [DATA_W-1:0]         app_in_data_o;
  logic                      app_in_valid_o;
  logic                      app_in_ready_i;

  modport master (
    input  req_data_i, req_valid_i, req_last_i, app_in_ready_i,
    output req_ready_o, app_in_data_o, app_in_valid_o
  );

  modport slave (
    output req_data_i, req_valid_i, req_last_i, app_in_ready_i,
    input  req_ready_o, app_in_data_o, app_in_valid_o
  );
endinterface

// File: rtl/in_fifo_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               any_req
);

  logic found;
  int   slot;

  assign any_req = |req;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    slot  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot = int'(rr_ptr) + i;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && req[k] && (k == slot)) begin
          gnt[k] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/in_fifo_arbiter.sv
// Packet-granular round-robin arbiter sharing the byte-wide IN FIFO port among NUM_REQ sources.
// Optional idle-owner forced release is built only when IN_ARB_TIMEOUT_EN is defined.
module in_fifo_arbiter
  import in_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int MAX_BURST      = IN_MAX_PACKET_SIZE,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  in_fifo_arbiter_if.master  bus,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int PTR_W = ceil_log2(NUM_REQ);
  localparam int CNT_W = burst_cnt_w(MAX_BURST);

  arb_state_t         state_q;
  arb_state_t         state_d;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   g_idx;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic [NUM_REQ-1:0] pick;
  logic               any_req;
  logic               g_valid;
  logic               g_last;
  logic               xfer;
  logic               burst_full;
  logic               force_rel;
  logic               release_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req     (bus.req_valid_i),
    .rr_ptr  (rr_ptr_q),
    .gnt     (pick),
    .any_req (any_req)
  );

  // Decode the registered one-hot owner into its index and handshake bits.
  always_comb begin
    g_idx   = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_o[k]) begin
        g_idx   = PTR_W'(k);
        g_valid = bus.req_valid_i[k];
        g_last  = bus.req_last_i[k];
      end
    end
  end

  assign xfer        = (state_q == GRANT) && g_valid && bus.app_in_ready_i;
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign burst_full  = (cnt_inc == CNT_W'(MAX_BURST));
  assign release_hit = (xfer && (g_last || burst_full)) || force_rel;

`ifdef IN_ARB_TIMEOUT_EN
  localparam int IDLE_W = ceil_log2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_q;
  logic [IDLE_W-1:0] idle_inc;

  assign idle_inc  = idle_q + IDLE_W'(1);
  assign force_rel = (state_q == GRANT) && !g_valid && (idle_inc == IDLE_W'(TIMEOUT_CYCLES));

  // Owner-silence counter; timeout_o lands on the same edge as the IDLE entry.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idle_q    <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= force_rel;
      if ((state_q != GRANT) || g_valid || force_rel) idle_q <= '0;
      else                                            idle_q <= idle_inc;
    end
  end
`else
  wire [31:0] unused_timeout_cycles = 32'(TIMEOUT_CYCLES);

  assign force_rel = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)     state_d = GRANT;
      GRANT:   if (release_hit) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o             = (state_q == GRANT);
    bus.app_in_data_o  = '0;
    bus.app_in_valid_o = 1'b0;
    bus.req_ready_o    = '0;
    if (state_q == GRANT) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant_o[k]) begin
          bus.app_in_data_o  = bus.req_data_i[DATA_W*k +: DATA_W];
          bus.app_in_valid_o = bus.req_valid_i[k];
          bus.req_ready_o[k] = bus.app_in_ready_i;
        end
      end
    end
  end

  // Grant, burst count and round-robin pointer; the pointer only moves on release.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      grant_o  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) grant_o <= pick;
        end
        GRANT: begin
          if (release_hit) begin
            grant_o  <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + PTR_W'(1);
          end else if (xfer) begin
            cnt_q <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_in_fifo_arbiter.sv
// Bench for in_fifo_arbiter: directed reset/gap scenarios plus randomized message phases
// checked by a scoreboard fed from a packet-level round-robin reference.
module tb_in_fifo_arbiter;
  import in_arb_pkg::*;

  localparam int N  = 3;
  localparam int MB = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] grant;
  logic         busy;
  logic         timeout;

  in_fifo_arbiter_if #(.NUM_REQ(N)) bus ();

  in_fifo_arbiter #(
    .NUM_REQ        (N),
    .MAX_BURST      (MB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus),
    .grant_o   (grant),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard entries are {source index, byte}.
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;
  logic       mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!busy) chk("quiet_when_idle", 32'({bus.app_in_valid_o, bus.req_ready_o}), 32'd0);
      if (bus.app_in_valid_o && bus.app_in_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'(bus.app_in_data_o), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("byte_data", 32'(bus.app_in_data_o), 32'(mon_e[7:0]));
          chk("byte_src", 32'(grant), 32'd1 << mon_e[9:8]);
        end
      end
    end
  end

  // Per-requester pending bytes {last, data}; the reference works on a copy.
  logic [8:0]   src_q[N][$];
  logic [8:0]   mq[N][$];
  int           mptr = 0;
  logic [N-1:0] acc;

  task automatic drive_sources();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0) begin
        bus.req_valid_i[k]         = 1'b1;
        bus.req_last_i[k]          = src_q[k][0][8];
        bus.req_data_i[8*k +: 8]   = src_q[k][0][7:0];
      end else begin
        bus.req_valid_i[k]         = 1'b0;
        bus.req_last_i[k]          = 1'b0;
        bus.req_data_i[8*k +: 8]   = 8'($urandom);
      end
    end
  endtask

  task automatic load_phase(input int ph);
    int nm, len, g, n;
    logic [8:0] ent;
    logic done;
    for (int k = 0; k < N; k++) begin
      if (ph == 0)      nm = (k == 0) ? 2 : 1;
      else if (ph == 1) nm = (k == 0) ? 0 : 1;
      else              nm = $urandom_range(0, 3);
      for (int m = 0; m < nm; m++) begin
        if (ph == 0)      len = 2;
        else if (ph == 1) len = (k == 1) ? 20 : 3;
        else              len = $urandom_range(1, 20);
        for (int b = 0; b < len; b++) src_q[k].push_back({(b == len - 1), 8'($urandom)});
      end
      mq[k] = src_q[k];
    end
    // Reference: owner = first pending source from the pointer; it sends until last or MB bytes.
    while (mq[0].size() + mq[1].size() + mq[2].size() > 0) begin
      g = -1;
      for (int i = 0; i < N; i++)
        if (g < 0 && mq[(mptr + i) % N].size() > 0) g = (mptr + i) % N;
      n = 0;
      done = 1'b0;
      while (!done) begin
        ent = mq[g].pop_front();
        exp_q.push_back({2'(g), ent[7:0]});
        n++;
        done = ent[8] || (n == MB);
      end
      mptr = (g + 1) % N;
    end
  endtask

  task automatic do_reset();
    bus.req_valid_i    = '0;
    bus.req_last_i     = '0;
    bus.app_in_ready_i = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int cyc;
    bus.req_valid_i    = 3'b111;
    bus.req_last_i     = 3'b000;
    bus.req_data_i     = {8'hC2, 8'hB1, 8'hA0};
    bus.app_in_ready_i = 1'b1;

    // Reset held with every source valid.
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_app_valid", 32'(bus.app_in_valid_o), 32'd0);
    chk("rst_app_data", 32'(bus.app_in_data_o), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    bus.req_last_i = 3'b001;
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_grant", 32'(grant), 32'b001);
    chk("first_data", 32'({bus.app_in_valid_o, bus.app_in_data_o}), 32'h1A0);
    chk("first_ready", 32'(bus.req_ready_o), 32'b001);
    @(negedge clk);
    chk("release_idle", 32'({busy, grant}), 32'd0);
    @(negedge clk);
    chk("rr_next_grant", 32'(grant), 32'b010);
    chk("rr_next_data", 32'(bus.app_in_data_o), 32'hB1);
    chk("rr_next_ready", 32'(bus.req_ready_o), 32'b010);
    repeat (4) @(negedge clk);
    chk("midburst_hold", 32'(grant), 32'b010);
    reset_n = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grant), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_valid", 32'(bus.app_in_valid_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("restart_from_0", 32'(grant), 32'b001);

    // Owner drops valid mid-burst while requester 1 waits.
    do_reset();
    bus.req_valid_i = 3'b011;
    bus.req_data_i  = {8'h22, 8'h11, 8'h10};
    @(negedge clk);
    chk("gap_grant", 32'(grant), 32'b001);
    repeat (3) @(negedge clk);
    bus.req_valid_i[0] = 1'b0;
`ifdef IN_ARB_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge clk);
      chk("to_hold", 32'(grant), 32'b001);
      chk("to_quiet", 32'(timeout), 32'd0);
    end
    @(negedge clk);
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_released", 32'(grant), 32'd0);
    @(negedge clk);
    chk("to_next_owner", 32'(grant), 32'b010);
    chk("to_pulse_end", 32'(timeout), 32'd0);
`else
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("gap_hold", 32'(grant), 32'b001);
      chk("gap_stall1", 32'(bus.req_ready_o[1]), 32'd0);
      chk("gap_no_timeout", 32'(timeout), 32'd0);
    end
    bus.req_valid_i[0]   = 1'b1;
    bus.req_last_i[0]    = 1'b1;
    bus.req_data_i[7:0]  = 8'h5A;
    #1;
    chk("gap_late_byte", 32'({bus.app_in_valid_o, bus.app_in_data_o}), 32'h15A);
    @(negedge clk);
    chk("gap_release", 32'(grant), 32'd0);
    @(negedge clk);
    chk("gap_next_owner", 32'(grant), 32'b010);
`endif

    // Randomized phases against the packet-level reference.
    do_reset();
    mptr   = 0;
    mon_en = 1'b1;
    for (int ph = 0; ph < 8; ph++) begin
      load_phase(ph);
      drive_sources();
      cyc = 0;
      while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + exp_q.size() > 0) && cyc < 4000) begin
        @(negedge clk);
        acc = bus.req_valid_i & bus.req_ready_o;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) if (acc[k]) void'(src_q[k].pop_front());
        drive_sources();
        bus.app_in_ready_i = (ph == 0) ? ~bus.app_in_ready_i : ($urandom_range(0, 3) != 0);
        cyc++;
      end
      chk("phase_in_budget", 32'(cyc < 4000), 32'd1);
      repeat (3) @(negedge clk);
      chk("phase_drained", 32'(exp_q.size()), 32'd0);
      chk("phase_idle", 32'({busy, grant}), 32'd0);
      for (int k = 0; k < N; k++) src_q[k].delete();
      exp_q.delete();
    end
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
